qnigma_fifo_pkt_rd: RTL and testbench

QNIGMA_FIFO_PKT_RD -- requirements
Module: qnigma_fifo_pkt_rd

---
 rtl/qnigma_pkg.sv | 19 +
 rtl/qnigma_fifo_rd_buf.sv | 67 ++++++
 rtl/qnigma_fifo_pkt_rd.sv | 139 +++++++++++++
 tb/tb_qnigma_fifo_pkt_rd.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qnigma_pkg.sv
// Shared types and constants for the qnigma packet read path.
// Holds the packet-reader FSM encoding and the skid-buffer depth.
package qnigma_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam int BUF_DEPTH = 3;
   localparam int BUF_CW    = 2;
   localparam logic [BUF_CW-1:0] BUF_FULL = BUF_CW'(BUF_DEPTH);

   // Ring-pointer advance that wraps at BUF_DEPTH rather than at a power of two.
   function automatic logic [BUF_CW-1:0] buf_ptr_inc(input logic [BUF_CW-1:0] p);
      return (p == BUF_CW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

endpackage

// File: rtl/qnigma_fifo_rd_buf.sv
// Three-entry in-order buffer between the FIFO read port and the output stream.
// A push into a full buffer or a pop from an empty one is ignored.
module qnigma_fifo_rd_buf
   import qnigma_pkg::*;
#(
   parameter int W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [W-1:0]      din,
   input  logic              pop,
   output logic [W-1:0]      dout,
   output logic [BUF_CW-1:0] cnt
);

   logic [W-1:0]      mem_q [BUF_DEPTH];
   logic [W-1:0]      mem_d [BUF_DEPTH];
   logic [BUF_CW-1:0] wr_ptr_q, wr_ptr_d;
   logic [BUF_CW-1:0] rd_ptr_q, rd_ptr_d;
   logic [BUF_CW-1:0] cnt_q, cnt_d;
   logic              do_push;
   logic              do_pop;

   assign do_push = push && (cnt_q != BUF_FULL);
   assign do_pop  = pop && (cnt_q != '0);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = buf_ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
         rd_ptr_d = buf_ptr_inc(rd_ptr_q);
      end
      // Simultaneous push and pop leaves the count untouched.
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign dout = mem_q[rd_ptr_q];
   assign cnt  = cnt_q;

endmodule

// File: rtl/qnigma_fifo_pkt_rd.sv
// Reads one packet of len words from a single-clock FIFO and emits it as a
// valid/ready stream with sof/eof framing and a done pulse.
module qnigma_fifo_pkt_rd
   import qnigma_pkg::*;
#(
   parameter int W  = 16,
   parameter int LW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [LW-1:0] len,
   output logic          fifo_read,
   input  logic [W-1:0]  fifo_data,
   input  logic          fifo_valid,
   input  logic          fifo_empty,
   output logic [W-1:0]  m_dat,
   output logic          m_val,
   output logic          m_sof,
   output logic          m_eof,
   input  logic          m_rdy,
   output logic          busy,
   output logic          done,
   output logic          err,
   output state_t        dbg_state
);

   // Stream handshake: a word transfers on a rising edge where m_val && m_rdy;
   // once m_val is high, m_dat/m_sof/m_eof hold until that transfer.

   state_t            state_q, state_d;
   logic [LW-1:0]     len_q, len_d;
   logic [LW-1:0]     issued_q, issued_d;
   logic [LW-1:0]     sent_q, sent_d;
   logic              inflight_q, inflight_d;
   logic              err_q, err_d;
   logic              done_q, done_d;

   logic [W-1:0]      buf_dout;
   logic [BUF_CW-1:0] buf_cnt;
   logic              buf_full;
   logic [2:0]        occ;
   logic              rd_en;
   logic              push;
   logic              hs;

   // Credit check uses only registered counts, so m_rdy never reaches fifo_read.
   assign occ      = {1'b0, buf_cnt} + {2'b00, inflight_q};
   assign buf_full = (buf_cnt == BUF_FULL);
   assign rd_en    = !rst && (state_q == ST_RUN) && !fifo_empty &&
                     (issued_q < len_q) && (occ < 3'(BUF_DEPTH));
   assign push     = fifo_valid && inflight_q && !buf_full;
   assign hs       = m_val && m_rdy;

   qnigma_fifo_rd_buf #(.W(W)) u_buf (
      .clk  (clk),
      .rst  (rst),
      .push (push),
      .din  (fifo_data),
      .pop  (hs),
      .dout (buf_dout),
      .cnt  (buf_cnt)
   );

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      issued_d   = issued_q;
      sent_d     = sent_q;
      inflight_d = inflight_q;
      err_d      = err_q;
      done_d     = 1'b0;

      if (rd_en) begin
         issued_d   = issued_q + LW'(1);
         inflight_d = 1'b1;
      end else if (fifo_valid) begin
         inflight_d = 1'b0;
      end

      // Unsolicited or overflowing read data is dropped and flagged.
      if (fifo_valid && (!inflight_q || buf_full)) begin
         err_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (start && (len != '0)) begin
               len_d    = len;
               issued_d = '0;
               sent_d   = '0;
               state_d  = ST_RUN;
            end
         end
         ST_RUN: begin
            if (hs) begin
               sent_d = sent_q + LW'(1);
               if (m_eof) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         len_q      <= '0;
         issued_q   <= '0;
         sent_q     <= '0;
         inflight_q <= 1'b0;
         err_q      <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         issued_q   <= issued_d;
         sent_q     <= sent_d;
         inflight_q <= inflight_d;
         err_q      <= err_d;
         done_q     <= done_d;
      end
   end

   // Outputs are masked by rst so they read zero while reset is held.
   assign fifo_read = rd_en;
   assign m_val     = (buf_cnt != '0) && !rst;
   assign m_dat     = m_val ? buf_dout : '0;
   assign m_sof     = m_val && (sent_q == '0);
   assign m_eof     = m_val && (sent_q == (len_q - LW'(1)));
   assign busy      = (state_q == ST_RUN) && !rst;
   assign done      = done_q && !rst;
   assign err       = err_q && !rst;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_qnigma_fifo_pkt_rd.sv
// Bench for qnigma_fifo_pkt_rd: upstream FIFO model, randomized packets and
// ready patterns, and a word-log reference of what each packet must carry.
module tb_qnigma_fifo_pkt_rd;
   import qnigma_pkg::*;

   localparam int W  = 16;
   localparam int LW = 16;

   // ---------------- clock / reset / DUT ----------------
   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [LW-1:0] len = '0;
   logic          fifo_read;
   logic [W-1:0]  fifo_data = '0;
   logic          fifo_valid = 1'b0;
   logic          fifo_empty = 1'b1;
   logic [W-1:0]  m_dat;
   logic          m_val, m_sof, m_eof;
   logic          m_rdy = 1'b0;
   logic          busy, done, err;
   state_t        dbg_state;

   always #5 clk = ~clk;

   qnigma_fifo_pkt_rd #(.W(W), .LW(LW)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .len        (len),
      .fifo_read  (fifo_read),
      .fifo_data  (fifo_data),
      .fifo_valid (fifo_valid),
      .fifo_empty (fifo_empty),
      .m_dat      (m_dat),
      .m_val      (m_val),
      .m_sof      (m_sof),
      .m_eof      (m_eof),
      .m_rdy      (m_rdy),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .dbg_state  (dbg_state)
   );

   // ---------------- scoreboard state ----------------
   int n_tests = 0;
   int n_fail  = 0;

   logic [W-1:0] fifo_q[$];   // words currently held by the upstream FIFO
   logic [W-1:0] exp_q[$];    // every word ever written, in order
   int  pop_cnt = 0;
   int  cyc = 0;
   bit  inject = 0;
   int  rdy_mode = 0;         // 0: always ready, 1: toggling, 2: random

   bit  pkt_active = 0;
   int  pkt_base = 0;
   int  pkt_len = 0;
   int  beat = 0;
   int  first_rd_cyc = -1;
   bit  seen_val = 0;
   int  hs_first = 0;
   int  hs_last = 0;
   bit  eof_last = 0;
   bit  stall_last = 0;
   logic [W-1:0] prev_dat = '0;
   logic prev_sof = 1'b0;
   logic prev_eof = 1'b0;
   bit  err_exp = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
      end
   endtask

   // ---------------- upstream FIFO model and ready driver ----------------
   always @(posedge clk) begin
      bit take;
      take = fifo_read && !fifo_empty;
      if (take && pkt_active && first_rd_cyc < 0) first_rd_cyc = cyc;
      #1;
      cyc++;
      if (take) begin
         fifo_data  = fifo_q.pop_front();
         pop_cnt++;
         fifo_valid = 1'b1;
      end else if (inject) begin
         fifo_data  = W'($urandom);
         fifo_valid = 1'b1;
         inject     = 0;
      end else begin
         fifo_valid = 1'b0;
      end
      fifo_empty = (fifo_q.size() == 0);
      case (rdy_mode)
         0:       m_rdy = 1'b1;
         1:       m_rdy = ~m_rdy;
         default: m_rdy = 1'($urandom_range(0, 1));
      endcase
   end

   // ---------------- stream monitor ----------------
   always @(negedge clk) begin
      if (!rst) begin
         check("done", done, eof_last);
         if (eof_last) check("busy_after_eof", busy, 0);
         check("err", err, err_exp);
         if (stall_last) begin
            check("stall_val", m_val, 1);
            check("stall_dat", m_dat, prev_dat);
            check("stall_sof", m_sof, prev_sof);
            check("stall_eof", m_eof, prev_eof);
         end
         eof_last = 0;
         if (!pkt_active) begin
            check("val_idle", m_val, 0);
         end else if (m_val) begin
            if (!seen_val) begin
               seen_val = 1;
               check("latency", (first_rd_cyc >= 0) && (cyc - first_rd_cyc >= 2), 1);
            end
            check("occupancy", (pop_cnt - pkt_base - beat) <= 3, 1);
            if (m_rdy) begin
               if (pkt_base + beat < exp_q.size())
                  check("dat", m_dat, exp_q[pkt_base + beat]);
               else
                  check("dat_unwritten", 1, 0);
               check("sof", m_sof, beat == 0);
               check("eof", m_eof, beat == pkt_len - 1);
               if (beat == 0) hs_first = cyc;
               hs_last = cyc;
               beat++;
               if (beat == pkt_len) begin
                  pkt_active = 0;
                  eof_last   = 1;
               end
            end
         end
         stall_last = m_val && !m_rdy;
         prev_dat   = m_dat;
         prev_sof   = m_sof;
         prev_eof   = m_eof;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic fifo_write(input logic [W-1:0] d);
      fifo_q.push_back(d);
      exp_q.push_back(d);
   endtask

   task automatic check_zero(input string pfx);
      check({pfx, "_fifo_read"}, fifo_read, 0);
      check({pfx, "_m_val"}, m_val, 0);
      check({pfx, "_m_sof"}, m_sof, 0);
      check({pfx, "_m_eof"}, m_eof, 0);
      check({pfx, "_busy"}, busy, 0);
      check({pfx, "_done"}, done, 0);
      check({pfx, "_err"}, err, 0);
      check({pfx, "_m_dat"}, m_dat, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst        = 1'b1;
      pkt_active = 0;
      stall_last = 0;
      eof_last   = 0;
      err_exp    = 0;
      #1;
      check_zero("rst_held");
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_zero("rst_after");
   endtask

   task automatic start_pkt(input int l);
      int n;
      n = 0;
      @(negedge clk);
      while (busy && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (busy) check("start_wait_timeout", 1, 0);
      start = 1'b1;
      len   = LW'(l);
      if (l != 0) begin
         pkt_base     = pop_cnt;
         pkt_len      = l;
         beat         = 0;
         seen_val     = 0;
         first_rd_cyc = -1;
         hs_first     = 0;
         hs_last      = 0;
         pkt_active   = 1;
      end
      @(negedge clk);
      start = 1'b0;
      len   = '0;
   endtask

   task automatic wait_pkt(input int max_cyc);
      int n;
      n = 0;
      while (pkt_active && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      if (pkt_active) begin
         check("pkt_timeout", 1, 0);
         pkt_active = 0;
      end
      repeat (2) @(negedge clk);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n;
      int l;
      int pre;
      rdy_mode = 0;
      do_reset();

      // Back-to-back packet of four at full rate.
      for (int i = 0; i < 4; i++) fifo_write(W'(16'hA0 + i));
      start_pkt(4);
      wait_pkt(200);
      check("full_rate_span", hs_last - hs_first, 3);

      // Single-word packet.
      fifo_write(W'(16'h55));
      start_pkt(1);
      wait_pkt(200);
      check("len1_busy", busy, 0);

      // Toggling ready.
      rdy_mode = 1;
      for (int i = 0; i < 8; i++) fifo_write(W'($urandom));
      start_pkt(8);
      wait_pkt(300);

      // FIFO runs dry mid-packet and refills later.
      rdy_mode = 0;
      for (int i = 0; i < 3; i++) fifo_write(W'($urandom));
      start_pkt(6);
      repeat (10) @(negedge clk);
      for (int i = 0; i < 3; i++) fifo_write(W'($urandom));
      wait_pkt(300);
      check("refill_err", err, 0);

      // Reset after the second word, then a fresh short packet.
      for (int i = 0; i < 7; i++) fifo_write(W'($urandom));
      start_pkt(5);
      n = 0;
      while (beat < 2 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("abort_reached_word2", beat >= 2, 1);
      do_reset();
      start_pkt(2);
      wait_pkt(200);

      // Randomized packets, ready and refill timing.
      rdy_mode = 2;
      for (int r = 0; r < 12; r++) begin
         l   = $urandom_range(1, 8);
         pre = $urandom_range(0, l);
         for (int i = 0; i < pre; i++) fifo_write(W'($urandom));
         start_pkt(l);
         fork
            begin
               for (int i = pre; i < l; i++) begin
                  repeat ($urandom_range(0, 4)) @(negedge clk);
                  fifo_write(W'($urandom));
               end
            end
            wait_pkt(1000);
         join
      end

      // Unsolicited read data sets a sticky error.
      rdy_mode = 0;
      @(negedge clk);
      inject = 1;
      @(posedge clk);
      @(posedge clk);
      #2;
      err_exp = 1;
      repeat (3) @(negedge clk);
      check("err_sticky", err, 1);

      // Zero-length start is ignored.
      start_pkt(0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("len0_busy", busy, 0);
         check("len0_done", done, 0);
      end

      do_reset();
      @(negedge clk);
      check("err_cleared", err, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
